arbitro_pulsadores: RTL and testbench

Round controller that shares the three front-panel pushbuttons (P1–P3) between players. It debounces each button, grants the round to the first valid press with fixed priority on ties, and locks out the other buttons until the grant is released. It aborts an armed round after a programmable number of seconds without a press. It sits between the raw pushbutton pins and the game/display logic, and is timed by a one-second strobe from the clock-divider chain.

---
 rtl/arbitro_pulsadores.sv | 140 ++++++++++++++
 tb/tb_arbitro_pulsadores.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_pulsadores.sv
// Three-button round arbiter: per-button sync + debounce lanes, rising-edge
// press pulses, and a round FSM with first-press grant, timeout and hold release.

module arbitro_pulsadores_deb #(
    parameter int DEB_CYCLES = 40000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic pin,
    output logic level
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Counter tracks how long the synchronized sample has disagreed with level.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module arbitro_pulsadores #(
    parameter int CLK_HZ     = 4000000,
    parameter int DEB_CYCLES = 40000,
    parameter int TIMEOUT_S  = 10,
    parameter int HOLD_S     = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       P1,
    input  logic       P2,
    input  logic       P3,
    input  logic       arm,
    input  logic       ack,
    output logic [2:0] press,
    output logic       armed,
    output logic       grant_valid,
    output logic [1:0] grant,
    output logic       timeout
);
    localparam int NUM_BTN = 3;

    typedef enum logic [1:0] {IDLE, ARMED, GRANTED, EXPIRE} state_t;

    logic [NUM_BTN-1:0] pins;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_d;
    state_t             state;
    logic [3:0]         sec;
    logic [3:0]         sec_inc;

    assign pins    = {P3, P2, P1};
    assign sec_inc = sec + 4'd1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        arbitro_pulsadores_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_in (clk_in),
            .reset  (reset),
            .pin    (pins[i]),
            .level  (level[i])
        );
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            level_d <= '0;
            press   <= '0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

    // Outputs are registered alongside the state so they never see input glitches.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state       <= IDLE;
            sec         <= '0;
            armed       <= 1'b0;
            grant_valid <= 1'b0;
            grant       <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        sec   <= '0;
                        armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (|press) begin
                        state       <= GRANTED;
                        sec         <= '0;
                        armed       <= 1'b0;
                        grant_valid <= 1'b1;
                        grant       <= press[0] ? 2'd1 : (press[1] ? 2'd2 : 2'd3);
                    end else if (tick_1hz) begin
                        sec <= sec_inc;
                        if (sec_inc == 4'(TIMEOUT_S)) begin
                            state   <= EXPIRE;
                            armed   <= 1'b0;
                            timeout <= 1'b1;
                        end
                    end
                end
                GRANTED: begin
                    if (ack || (tick_1hz && sec_inc == 4'(HOLD_S))) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        grant       <= '0;
                    end else if (tick_1hz) begin
                        sec <= sec_inc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_pulsadores.sv
// Directed and random bench for arbitro_pulsadores against a window-based
// debounce model and a round-rules model.

module tb_arbitro_pulsadores;
    localparam int DEB  = 4;
    localparam int TO   = 2;
    localparam int HOLD = 3;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       P1 = 1'b0, P2 = 1'b0, P3 = 1'b0;
    logic       arm = 1'b0, ack = 1'b0;
    logic [2:0] press;
    logic       armed, grant_valid, timeout;
    logic [1:0] grant;

    arbitro_pulsadores #(.CLK_HZ(4000000), .DEB_CYCLES(DEB), .TIMEOUT_S(TO), .HOLD_S(HOLD)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .P1          (P1),
        .P2          (P2),
        .P3          (P3),
        .arm         (arm),
        .ack         (ack),
        .press       (press),
        .armed       (armed),
        .grant_valid (grant_valid),
        .grant       (grant),
        .timeout     (timeout)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // Reference: a button level flips once the last DEB synchronized samples
    // all disagree with it; rounds follow the arm/press/tick/ack rules.
    logic [2:0]     m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl_d = '0, m_press = '0;
    logic [DEB-1:0] hist [3];
    int             m_st = 0;  // 0 idle, 1 armed, 2 granted, 3 expire
    int             m_sec = 0;
    logic [1:0]     m_grant = '0;

    task automatic model_edge(input logic r, input logic [2:0] p, input logic a, input logic k, input logic t);
        logic [2:0] newlvl;
        logic [2:0] newpress;
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_press = '0;
            for (int i = 0; i < 3; i++) hist[i] = '0;
            m_st = 0; m_sec = 0; m_grant = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                hist[i] = {hist[i][DEB-2:0], m_s2[i]};
                newlvl[i] = (hist[i] == {DEB{~m_lvl[i]}}) ? ~m_lvl[i] : m_lvl[i];
            end
            newpress = m_lvl & ~m_lvl_d;
            case (m_st)
                0: if (a) begin m_st = 1; m_sec = 0; end
                1: begin
                    if (m_press != 3'b000) begin
                        m_st = 2; m_sec = 0;
                        m_grant = m_press[0] ? 2'd1 : (m_press[1] ? 2'd2 : 2'd3);
                    end else if (t) begin
                        m_sec++;
                        if (m_sec == TO) m_st = 3;
                    end
                end
                2: begin
                    if (k) m_st = 0;
                    else if (t) begin
                        m_sec++;
                        if (m_sec == HOLD) m_st = 0;
                    end
                end
                default: m_st = 0;
            endcase
            m_s2 = m_s1; m_s1 = p;
            m_lvl_d = m_lvl; m_lvl = newlvl; m_press = newpress;
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] obs, exp;
        obs = {press, armed, grant_valid, grant, timeout};
        exp = {m_press, m_st == 1, m_st == 2, (m_st == 2) ? m_grant : 2'd0, m_st == 3};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Model-independent spot checks of specific output values.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] p, input logic a, input logic k, input logic t, input string tag);
        @(negedge clk_in);
        reset = r; {P3, P2, P1} = p; arm = a; ack = k; tick_1hz = t;
        @(posedge clk_in);
        model_edge(r, p, a, k, t);
        #1;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '0;

        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "reset");
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "reset");
        chk("reset_outputs", {press, armed, grant_valid, grant, timeout}, 8'h00);
        idle(3, "post_reset");

        // First press latency: grant 7 edges after P2 is first sampled.
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm1");
        chk("armed_after_arm", {armed, grant_valid}, 8'b10);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, "hold_p2");
            if (i == 6) chk("press_p2_pulse", {press, grant_valid}, {3'b010, 1'b0});
            if (i == 7) chk("grant_p2_edge7", {grant_valid, grant}, {1'b1, 2'd2});
        end
        step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, "ack1");
        chk("grant_cleared_by_ack", {grant_valid, grant}, 8'b000);
        idle(8, "settle1");

        // Bounce on P1 shorter than the debounce window, then a real press.
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm2");
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, "bounce_hi");
            for (int i = 0; i < 2; i++) step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, "bounce_lo");
        end
        chk("bounce_no_grant", {press, armed, grant_valid}, {3'b000, 1'b1, 1'b0});
        for (int i = 0; i < 10; i++) step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, "hold_p1");
        chk("grant_p1", {grant_valid, grant}, {1'b1, 2'd1});
        idle(8, "release_p1");
        step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, "ack2");

        // Tie P1/P3, then a locked-out P3 press.
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm3");
        for (int i = 0; i < 9; i++) step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, "hold_p1p3");
        chk("tie_grant_p1", {grant_valid, grant}, {1'b1, 2'd1});
        idle(8, "release_tie");
        for (int i = 0; i < 9; i++) step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, "p3_locked");
        chk("lockout_grant_stays_1", {grant_valid, grant}, {1'b1, 2'd1});
        step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, "ack3");
        idle(8, "settle3");

        // Timeout after TO ticks.
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm4");
        idle(2, "wait4");
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "tick4a");
        idle(2, "wait4");
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "tick4b");
        chk("timeout_pulse", {armed, timeout}, 8'b01);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, "after_timeout");
        chk("timeout_one_cycle", {armed, timeout}, 8'b00);

        // Press coinciding with the expiring tick wins.
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm5");
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "tick5a");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'b010, 1'b0, 1'b0, (i == 7), "press_vs_tick");
            if (i == 7) chk("press_beats_timeout", {grant_valid, grant, timeout}, {1'b1, 2'd2, 1'b0});
        end

        // Auto-release after HOLD ticks; wrong-state arm/ack ignored.
        idle(8, "release_p2");
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm_in_granted");
        chk("arm_ignored_granted", {armed, grant_valid}, 8'b01);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "hold_tick1");
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "hold_tick2");
        chk("still_granted", {grant_valid, grant}, {1'b1, 2'd2});
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "hold_tick3");
        chk("auto_release", {grant_valid, grant}, 8'b000);
        step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, "ack_in_idle");
        chk("ack_ignored_idle", {armed, grant_valid}, 8'b00);

        // Reset mid-grant, then a held button pulses but is not granted.
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm6");
        for (int i = 0; i < 9; i++) step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, "hold_p1_6");
        step(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, "reset_mid");
        chk("reset_mid_outputs", {press, armed, grant_valid, grant, timeout}, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, "held_after_reset");
        chk("no_grant_after_reset", {armed, grant_valid}, 8'b00);
        idle(8, "release6");
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "arm7");
        for (int i = 0; i < 9; i++) step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, "hold_p3_7");
        chk("grant_p3", {grant_valid, grant}, {1'b1, 2'd3});

        // Random traffic with bursty button levels.
        begin
            logic [2:0] btn;
            btn = '0;
            for (int n = 0; n < 3000; n++) begin
                for (int b = 0; b < 3; b++)
                    if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
                step(($urandom_range(0, 399) != 0), btn,
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 5) == 0), "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
